// File: rtl/servant_uart_rx_pkg.sv
// Shared definitions for the servant UART receiver: FSM state encodings and 8N1 frame constants.
package servant_uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

endpackage

// File: rtl/servant_uart_fifo.sv
// First-word-fall-through byte FIFO with extra-MSB pointers for full/empty detection.
module servant_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a simultaneous push.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  assign o_rdata = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/servant_uart_rx.sv
// 8N1 receiver for the servant GPIO line: synchroniser, bit timer, framing FSM and byte FIFO.
//
// state | meaning
// IDLE  | line idle, waiting for a low level
// START | timing to start-bit midpoint, rejects glitches
// DATA  | sampling 8 data bits LSB first at bit midpoints
// STOP  | sampling stop bit; high pushes the byte, low flags a frame error
// BREAK | line held low after a frame error, waiting for it to return high
module servant_uart_rx
  import servant_uart_rx_pkg::*;
#(
  parameter int BAUD_DIV = 278,
  parameter int DEPTH    = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overflow,
  input  logic       i_clr
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV/2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(DATA_BITS - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           rx_meta_q, rx_s_q;
  logic           frame_err_q, frame_err_d;
  logic           overflow_q, overflow_d;
  logic           push;
  logic           pop;
  logic           fifo_empty;
  logic           fifo_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            state_d = ST_DATA;
            idx_d   = '0;
            cnt_d   = FULL_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = FULL_LOAD;
          if (idx_q == LAST_IDX) state_d = ST_STOP;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign pop = ~fifo_empty & i_ready;

  // A drop in the same cycle as a clear still leaves the flag set.
  assign overflow_d = (overflow_q & ~i_clr) | (push & fifo_full & ~pop);

  servant_uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_wdata (shift_d),
    .i_pop   (pop),
    .o_rdata (o_data),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  assign o_valid     = ~fifo_empty;
  assign o_frame_err = frame_err_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_servant_uart_rx.sv
// Directed bench for servant_uart_rx with BAUD_DIV=8, DEPTH=4.
module tb_servant_uart_rx;

  localparam int BD = 8;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       ferr;
  logic       ovf;
  logic       clr;

  int         pass_cnt;
  int         total_cnt;
  int         ferr_cnt;
  logic [7:0] rxq [$];

  servant_uart_rx #(.BAUD_DIV(BD), .DEPTH(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_frame_err (ferr),
    .o_overflow  (ovf),
    .i_clr       (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && valid && ready) rxq.push_back(data);
    if (rst_n && ferr) ferr_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    cycles(BD);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx = 1'b1; ready = 1'b0; clr = 1'b0;
    cycles(3);
    total_cnt++;
    if ({valid, data, ferr, ovf} !== 11'h0) $display("FAIL reset_outputs: got %0h expected 0", {valid, data, ferr, ovf});
    else pass_cnt++;
    rst_n = 1'b1;
    cycles(5);
  endtask

  task automatic test_two_frames;
    rxq.delete(); ferr_cnt = 0; ready = 1'b1;
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    cycles(20);
    total_cnt++;
    if (rxq.size() !== 2) $display("FAIL t1_count: got %0d expected 2", rxq.size());
    else pass_cnt++;
    if (rxq.size() == 2) begin
      total_cnt++;
      if (rxq[0] !== 8'h55) $display("FAIL t1_byte0: got %0h expected 55", rxq[0]);
      else pass_cnt++;
      total_cnt++;
      if (rxq[1] !== 8'hA3) $display("FAIL t1_byte1: got %0h expected a3", rxq[1]);
      else pass_cnt++;
    end
    total_cnt++;
    if (ferr_cnt !== 0 || ovf !== 1'b0) $display("FAIL t1_flags: got ferr=%0d ovf=%0b expected 0 0", ferr_cnt, ovf);
    else pass_cnt++;
  endtask

  task automatic test_glitch;
    rxq.delete(); ferr_cnt = 0; ready = 1'b1;
    rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    cycles(30);
    total_cnt++;
    if (rxq.size() !== 0 || valid !== 1'b0) $display("FAIL t2_no_byte: got size=%0d valid=%0b expected 0 0", rxq.size(), valid);
    else pass_cnt++;
    total_cnt++;
    if (ferr_cnt !== 0) $display("FAIL t2_no_ferr: got %0d expected 0", ferr_cnt);
    else pass_cnt++;
  endtask

  task automatic test_break;
    rxq.delete(); ferr_cnt = 0; ready = 1'b1;
    send_frame(8'h7E, 1'b0);
    rx = 1'b0;
    cycles(40);
    rx = 1'b1;
    cycles(2*BD);
    send_frame(8'h11, 1'b1);
    cycles(20);
    total_cnt++;
    if (ferr_cnt !== 1) $display("FAIL t3_one_ferr: got %0d expected 1", ferr_cnt);
    else pass_cnt++;
    total_cnt++;
    if (rxq.size() !== 1) $display("FAIL t3_count: got %0d expected 1", rxq.size());
    else pass_cnt++;
    if (rxq.size() == 1) check("t3_byte", 32'(rxq[0]), 32'h11);
  endtask

  task automatic test_overflow;
    logic [7:0] exp [4];
    exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    rxq.delete(); ferr_cnt = 0; ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    cycles(20);
    check("t4_overflow_set", 32'(ovf), 32'h1);
    check("t4_head", 32'({valid, data}), 32'h101);
    ready = 1'b1;
    cycles(12);
    ready = 1'b0;
    total_cnt++;
    if (rxq.size() !== 4) $display("FAIL t4_count: got %0d expected 4", rxq.size());
    else pass_cnt++;
    for (int i = 0; i < 4; i++)
      if (i < rxq.size()) check("t4_drain", 32'(rxq[i]), 32'(exp[i]));
    check("t4_empty", 32'(valid), 32'h0);
    check("t4_ovf_before_clr", 32'(ovf), 32'h1);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    check("t4_ovf_cleared", 32'(ovf), 32'h0);
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp [5];
    exp = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h66};
    rxq.delete(); ferr_cnt = 0; ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'h60 + 8'(i), 1'b1);
    cycles(10);
    fork
      send_frame(8'h66, 1'b1);
      begin
        // stop-bit midpoint (the push edge) is the 79th edge after the start bit is driven
        cycles(78);
        ready = 1'b1;
        cycles(1);
        ready = 1'b0;
      end
    join
    cycles(20);
    check("t5_no_overflow", 32'(ovf), 32'h0);
    ready = 1'b1;
    cycles(12);
    ready = 1'b0;
    total_cnt++;
    if (rxq.size() !== 5) $display("FAIL t5_count: got %0d expected 5", rxq.size());
    else pass_cnt++;
    for (int i = 0; i < 5; i++)
      if (i < rxq.size()) check("t5_order", 32'(rxq[i]), 32'(exp[i]));
  endtask

  task automatic test_reset_mid_frame;
    rxq.delete(); ferr_cnt = 0; ready = 1'b0;
    send_frame(8'hAA, 1'b1);
    cycles(12);
    check("t6_pre_valid", 32'({valid, data}), 32'h1AA);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        cycles(44);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", 32'({valid, data, ferr, ovf}), 32'h0);
      end
    join
    cycles(2);
    rst_n = 1'b1;
    ready = 1'b1;
    cycles(2*BD);
    send_frame(8'h3C, 1'b1);
    cycles(20);
    total_cnt++;
    if (rxq.size() !== 1) $display("FAIL t6_count: got %0d expected 1", rxq.size());
    else pass_cnt++;
    if (rxq.size() == 1) check("t6_byte", 32'(rxq[0]), 32'h3C);
    check("t6_no_ferr", 32'(ferr_cnt), 32'h0);
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; ferr_cnt = 0;
    rst_n = 1'b0; rx = 1'b1; ready = 1'b0; clr = 1'b0;
    #2;
    test_reset;
    test_two_frames;
    test_glitch;
    test_break;
    test_overflow;
    test_full_push_pop;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
